// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART PISO transmitter between
// NUM_REQ byte requesters. It captures the winning byte and its parity mode,
// computes the parity bit, drives the PISO send/data/parity inputs, retires
// each frame on a PISO done rising edge, and aborts hung frames with a watchdog.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   req_valid         per-requester byte pending (held until req_ready)
//   req_data          byte i at bits [8i+7:8i]
//   req_parity_type   mode i at bits [2i+1:2i]: 00/11 none, 01 odd, 10 even
//   req_ready         combinational one-hot accept strobe (IDLE only)
//   complete          one-hot, one-cycle frame-done strobe
//   grant_id          owner of the current frame
//   busy              high whenever the FSM is not IDLE
//   timeout_err       one-cycle pulse on watchdog abort
//   piso_send/piso_data/piso_parity_type/piso_parity_bit   PISO controls
//   piso_active/piso_done   PISO status, already synchronized to clk
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*2-1:0]        req_parity_type,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          complete,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err,
    output logic                        piso_send,
    output logic [DATA_W-1:0]           piso_data,
    output logic [1:0]                  piso_parity_type,
    output logic                        piso_parity_bit,
    input  logic                        piso_active,
    input  logic                        piso_done
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RELEASE   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          ptype_q, ptype_d;
    logic                pbit_q, pbit_d;
    logic                send_q, send_d;
    logic [NUM_REQ-1:0]  complete_q, complete_d;
    logic                busy_q, busy_d;
    logic                tout_q, tout_d;
    logic [CNT_W-1:0]    wdog_q, wdog_d;
    logic                done_prev_q;

    logic [DATA_W-1:0]   data_arr  [NUM_REQ];
    logic [1:0]          ptype_arr [NUM_REQ];
    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic                done_rise;
    int                  cand_sum;

    function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic [1:0] t);
        case (t)
            2'b01:   return ~^d;
            2'b10:   return ^d;
            default: return 1'b0;
        endcase
    endfunction

    // Unpack the flat request buses into per-requester lanes.
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            data_arr[i]  = req_data[i*int'(DATA_W) +: DATA_W];
            ptype_arr[i] = req_parity_type[i*2 +: 2];
        end
    end

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand_sum  = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand_sum = int'(ptr_q) + i;
            if (cand_sum >= int'(NUM_REQ)) begin
                cand_sum = cand_sum - int'(NUM_REQ);
            end
            if (!win_found && req_valid[ID_W'(cand_sum)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(cand_sum);
            end
        end
    end

    // Accept strobe is combinational so a requester sees it in its valid cycle.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign done_rise = piso_done & ~done_prev_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        data_d     = data_q;
        ptype_d    = ptype_q;
        pbit_d     = pbit_q;
        send_d     = send_q;
        complete_d = '0;
        tout_d     = 1'b0;
        wdog_d     = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win_id;
                    data_d  = data_arr[win_id];
                    ptype_d = ptype_arr[win_id];
                    pbit_d  = parity_of(data_arr[win_id], ptype_arr[win_id]);
                    send_d  = 1'b1;
                    wdog_d  = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND, S_WAIT_DONE: begin
                // A done edge wins over a coinciding watchdog expiry.
                if (state_q == S_WAIT_DONE && done_rise) begin
                    complete_d[grant_q] = 1'b1;
                    state_d             = S_RELEASE;
                end else if (wdog_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    tout_d  = 1'b1;
                    send_d  = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (state_q == S_SEND && piso_active) begin
                        send_d  = 1'b0;
                        state_d = S_WAIT_DONE;
                    end
                end
            end
            S_RELEASE: begin
                // Hold off the next frame until the PISO has gone idle.
                if (!piso_active) begin
                    ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            data_q      <= '0;
            ptype_q     <= '0;
            pbit_q      <= 1'b0;
            send_q      <= 1'b0;
            complete_q  <= '0;
            busy_q      <= 1'b0;
            tout_q      <= 1'b0;
            wdog_q      <= '0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            data_q      <= data_d;
            ptype_q     <= ptype_d;
            pbit_q      <= pbit_d;
            send_q      <= send_d;
            complete_q  <= complete_d;
            busy_q      <= busy_d;
            tout_q      <= tout_d;
            wdog_q      <= wdog_d;
            done_prev_q <= piso_done;
        end
    end

    assign complete         = complete_q;
    assign grant_id         = grant_q;
    assign busy             = busy_q;
    assign timeout_err      = tout_q;
    assign piso_send        = send_q;
    assign piso_data        = data_q;
    assign piso_parity_type = ptype_q;
    assign piso_parity_bit  = pbit_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of parity vectors plus
// hand-written sequences for arbitration order, watchdog, reset and done edges.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [NR-1:0]  req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR*2-1:0] req_parity_type;
    logic [NR-1:0]  req_ready;
    logic [NR-1:0]  complete;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_err;
    logic           piso_send;
    logic [7:0]     piso_data;
    logic [1:0]     piso_parity_type;
    logic           piso_parity_bit;
    logic           piso_active;
    logic           piso_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_W(8), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data),
        .req_parity_type(req_parity_type), .req_ready(req_ready),
        .complete(complete), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .piso_send(piso_send),
        .piso_data(piso_data), .piso_parity_type(piso_parity_type),
        .piso_parity_bit(piso_parity_bit), .piso_active(piso_active),
        .piso_done(piso_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] d;
        logic [1:0] pt;
        logic       pbit;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] d, input logic [1:0] pt);
        req_data[id*8 +: 8]        = d;
        req_parity_type[id*2 +: 2] = pt;
    endtask

    // One complete frame served by a well-behaved PISO.
    task automatic frame(input logic [3:0] mask, input int id, input logic [7:0] d,
                         input logic [1:0] pt, input logic pbit, input logic keep);
        set_req(id, d, pt);
        req_valid = mask;
        #1;
        check("ready_same_cycle", 32'(req_ready), 32'(1) << id);
        step();
        if (!keep) req_valid[id] = 1'b0;
        check("send_next_cycle", 32'(piso_send), 32'd1);
        check("grant_id", 32'(grant_id), 32'(id));
        check("piso_data", 32'(piso_data), 32'(d));
        check("parity_type", 32'(piso_parity_type), 32'(pt));
        check("parity_bit", 32'(piso_parity_bit), 32'(pbit));
        check("single_ready", 32'(req_ready), 32'd0);
        piso_active = 1'b1;
        step();
        check("send_drop", 32'(piso_send), 32'd0);
        piso_done = 1'b1;
        step();
        check("complete", 32'(complete), 32'(1) << id);
        piso_done = 1'b0;
        step();
        check("complete_pulse", 32'(complete), 32'd0);
        check("hold_while_active", 32'({busy, req_ready}), 32'h10);
        piso_active = 1'b0;
        step();
        check("idle_after_release", 32'(busy), 32'd0);
    endtask

    int  cyc;
    logic seen_complete;

    initial begin
        vecs[0] = '{0, 8'h4A, 2'b00, 1'b0};
        vecs[1] = '{1, 8'h4A, 2'b01, 1'b0};
        vecs[2] = '{2, 8'h4A, 2'b10, 1'b1};
        vecs[3] = '{3, 8'h4A, 2'b11, 1'b0};
        vecs[4] = '{0, 8'h5A, 2'b00, 1'b0};
        vecs[5] = '{1, 8'h5A, 2'b01, 1'b1};
        vecs[6] = '{2, 8'h5A, 2'b10, 1'b0};
        vecs[7] = '{3, 8'h5A, 2'b11, 1'b0};

        reset           = 1'b1;
        req_valid       = '0;
        req_data        = '0;
        req_parity_type = '0;
        piso_active     = 1'b0;
        piso_done       = 1'b0;
        step();
        step();
        check("reset_outputs",
              32'({req_ready, complete, grant_id, busy, timeout_err, piso_send,
                   piso_data, piso_parity_type, piso_parity_bit}), 32'd0);
        reset = 1'b0;
        step();

        // Basic frame: odd parity on 0x4A.
        frame(4'b0001, 0, 8'h4A, 2'b01, 1'b0, 1'b0);

        // Parity matrix, one sole requester per vector.
        for (int v = 0; v < 8; v++) begin
            frame(4'b0001 << vecs[v].id, vecs[v].id, vecs[v].d, vecs[v].pt, vecs[v].pbit, 1'b0);
        end

        // All requesters continuously valid: order 0,1,2,3,0.
        for (int i = 0; i < NR; i++) set_req(i, 8'(8'h10 + i), 2'b00);
        for (int k = 0; k < 5; k++) begin
            frame(4'b1111, k % NR, 8'(8'h10 + (k % NR)), 2'b00, 1'b0, 1'b1);
        end
        req_valid = '0;

        // Watchdog: PISO never goes active.
        set_req(1, 8'hC3, 2'b10);
        req_valid = 4'b0010;
        #1;
        check("wd_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        check("wd_send", 32'(piso_send), 32'd1);
        cyc = 0;
        seen_complete = 1'b0;
        while (!timeout_err && cyc < 40) begin
            step();
            cyc++;
            if (complete != '0) seen_complete = 1'b1;
        end
        check("timeout_cycles", 32'(cyc), 32'(TO));
        check("timeout_no_complete", 32'(seen_complete), 32'd0);
        check("timeout_send_low", 32'(piso_send), 32'd0);
        step();
        check("timeout_pulse", 32'({timeout_err, busy}), 32'd0);
        frame(4'b0110, 2, 8'h81, 2'b01, 1'b1, 1'b0);
        req_valid = '0;

        // Reset while waiting for done.
        set_req(3, 8'hE7, 2'b10);
        req_valid = 4'b1000;
        #1;
        step();
        req_valid   = '0;
        piso_active = 1'b1;
        step();
        check("pre_reset_busy", 32'({busy, piso_send}), 32'h2);
        reset = 1'b1;
        step();
        check("mid_reset_outputs",
              32'({req_ready, complete, grant_id, busy, timeout_err, piso_send,
                   piso_data, piso_parity_type, piso_parity_bit}), 32'd0);
        reset       = 1'b0;
        piso_active = 1'b0;
        frame(4'b1001, 0, 8'h3C, 2'b01, 1'b1, 1'b0);
        req_valid = '0;

        // Done level already high on entry to WAIT_DONE.
        set_req(1, 8'h55, 2'b00);
        req_valid = 4'b0010;
        #1;
        check("lvl_ready", 32'(req_ready), 32'h2);
        step();
        req_valid   = '0;
        piso_active = 1'b1;
        piso_done   = 1'b1;
        step();
        check("lvl_entry_no_complete", 32'(complete), 32'd0);
        step();
        check("lvl_held_no_complete", 32'(complete), 32'd0);
        piso_done = 1'b0;
        step();
        check("lvl_low_no_complete", 32'(complete), 32'd0);
        piso_done = 1'b1;
        step();
        check("lvl_second_rise", 32'(complete), 32'h2);
        step();
        check("lvl_single_pulse", 32'({complete, busy}), 32'h1);
        piso_done   = 1'b0;
        piso_active = 1'b0;
        step();
        check("lvl_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
